// File: rtl/deadlock_wd_pkg.sv
// Shared types and constants for the deadlock watchdog controller.
package deadlock_wd_pkg;

  localparam int INFO_W_DEFAULT = 4;
  localparam int TRIP_CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_COUNTING = 2'd2,
    ST_TRIPPED  = 2'd3
  } wd_state_e;

endpackage

// File: rtl/deadlock_watchdog_ctrl.sv
// Watchdog above the per-dataflow deadlock monitors: times consecutive blocked
// cycles, snapshots the monitors on a trip and holds a sticky interrupt.
module deadlock_watchdog_ctrl
  import deadlock_wd_pkg::*;
#(
  parameter int NUM_MON  = 2,
  parameter int INFO_W   = INFO_W_DEFAULT,
  parameter int THRESH_W = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_MON-1:0]        mon_block,
  input  logic [NUM_MON*INFO_W-1:0] mon_info,
  input  logic                      cfg_enable,
  input  logic [THRESH_W-1:0]       cfg_threshold,
  input  logic                      irq_clear,
  output logic                      irq,
  output logic [1:0]                state,
  output logic [THRESH_W-1:0]       stall_count,
  output logic [NUM_MON-1:0]        latched_mon,
  output logic [NUM_MON*INFO_W-1:0] latched_info,
  output logic [TRIP_CNT_W-1:0]     trip_count
);

  wd_state_e           state_q, state_next;
  logic [THRESH_W-1:0] count_next;
  logic [THRESH_W-1:0] thr_eff;
  logic [THRESH_W:0]   count_inc;
  logic                any_block;
  logic                do_trip;
  logic                do_clear;

  assign any_block = |mon_block;
  assign thr_eff   = (cfg_threshold == '0) ? THRESH_W'(1) : cfg_threshold;
  // Extra carry bit keeps the compare honest even if the count sits at max.
  assign count_inc = {1'b0, stall_count} + 1'b1;
  assign state     = state_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_next = state_q;
    count_next = stall_count;
    do_trip    = 1'b0;
    do_clear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        count_next = '0;
        if (cfg_enable) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        count_next = '0;
        if (!cfg_enable) begin
          state_next = ST_IDLE;
        end else if (any_block) begin
          count_next = THRESH_W'(1);
          if (thr_eff == THRESH_W'(1)) begin
            state_next = ST_TRIPPED;
            do_trip    = 1'b1;
          end else begin
            state_next = ST_COUNTING;
          end
        end
      end
      ST_COUNTING: begin
        if (!cfg_enable) begin
          state_next = ST_IDLE;
          count_next = '0;
        end else if (!any_block) begin
          state_next = ST_ARMED;
          count_next = '0;
        end else begin
          count_next = count_inc[THRESH_W] ? '1 : count_inc[THRESH_W-1:0];
          // >= rather than == so a threshold lowered mid-count still trips.
          if (count_inc >= {1'b0, thr_eff}) begin
            state_next = ST_TRIPPED;
            do_trip    = 1'b1;
          end
        end
      end
      ST_TRIPPED: begin
        if (irq_clear) begin
          do_clear   = 1'b1;
          count_next = '0;
          state_next = cfg_enable ? ST_ARMED : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      stall_count  <= '0;
      irq          <= 1'b0;
      latched_mon  <= '0;
      latched_info <= '0;
      trip_count   <= '0;
    end else begin
      state_q     <= state_next;
      stall_count <= count_next;
      if (do_trip) begin
        irq          <= 1'b1;
        latched_mon  <= mon_block;
        latched_info <= mon_info;
        if (trip_count != '1) trip_count <= trip_count + 1'b1;
      end else if (do_clear) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deadlock_watchdog_ctrl.sv
// Directed self-checking bench for deadlock_watchdog_ctrl (NUM_MON=2, INFO_W=4).
module tb_deadlock_watchdog_ctrl;

  localparam int NUM_MON  = 2;
  localparam int INFO_W   = 4;
  localparam int THRESH_W = 16;

  logic                      clock;
  logic                      reset_n;
  logic [NUM_MON-1:0]        mon_block;
  logic [NUM_MON*INFO_W-1:0] mon_info;
  logic                      cfg_enable;
  logic [THRESH_W-1:0]       cfg_threshold;
  logic                      irq_clear;
  logic                      irq;
  logic [1:0]                state;
  logic [THRESH_W-1:0]       stall_count;
  logic [NUM_MON-1:0]        latched_mon;
  logic [NUM_MON*INFO_W-1:0] latched_info;
  logic [7:0]                trip_count;

  int n_checks = 0;
  int n_errors = 0;

  deadlock_watchdog_ctrl #(
    .NUM_MON (NUM_MON),
    .INFO_W  (INFO_W),
    .THRESH_W(THRESH_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .mon_block    (mon_block),
    .mon_info     (mon_info),
    .cfg_enable   (cfg_enable),
    .cfg_threshold(cfg_threshold),
    .irq_clear    (irq_clear),
    .irq          (irq),
    .state        (state),
    .stall_count  (stall_count),
    .latched_mon  (latched_mon),
    .latched_info (latched_info),
    .trip_count   (trip_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Advance past one rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mon_block = '0; mon_info = '0;
    cfg_enable = 1'b0; cfg_threshold = '0; irq_clear = 1'b0;
    tick(); tick();
    n_checks++; if (state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d exp 0", state); end
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %0b exp 0", irq); end
    n_checks++; if (stall_count !== 16'd0) begin n_errors++; $display("FAIL reset_stall: got %0d exp 0", stall_count); end
    n_checks++; if ({latched_mon, latched_info} !== 10'd0) begin n_errors++; $display("FAIL reset_latched: got %h/%h exp 0/0", latched_mon, latched_info); end
    n_checks++; if (trip_count !== 8'd0) begin n_errors++; $display("FAIL reset_trips: got %0d exp 0", trip_count); end
    reset_n = 1'b1;
    tick();
    n_checks++; if (state !== 2'd0) begin n_errors++; $display("FAIL idle_no_enable: got %0d exp 0", state); end
  endtask

  task automatic test_basic_trip();
    cfg_threshold = 16'd4; cfg_enable = 1'b1;
    tick();
    n_checks++; if (state !== 2'd1) begin n_errors++; $display("FAIL basic_armed: got %0d exp 1", state); end
    mon_block = 2'b10; mon_info = 8'hD0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if (stall_count !== 16'(k) || state !== 2'd2 || irq !== 1'b0) begin
        n_errors++; $display("FAIL basic_count%0d: got cnt=%0d st=%0d irq=%0b exp cnt=%0d st=2 irq=0", k, stall_count, state, irq, k);
      end
    end
    tick();
    n_checks++; if (irq !== 1'b1 || state !== 2'd3) begin n_errors++; $display("FAIL basic_trip: got irq=%0b st=%0d exp 1/3", irq, state); end
    n_checks++; if (latched_mon !== 2'b10 || latched_info !== 8'hD0) begin n_errors++; $display("FAIL basic_latch: got %b/%h exp 10/d0", latched_mon, latched_info); end
    n_checks++; if (stall_count !== 16'd4 || trip_count !== 8'd1) begin n_errors++; $display("FAIL basic_counts: got stall=%0d trips=%0d exp 4/1", stall_count, trip_count); end
    // Tripped ignores new monitor values and enable.
    mon_block = 2'b01; mon_info = 8'h33; cfg_enable = 1'b0;
    tick();
    n_checks++; if (irq !== 1'b1 || state !== 2'd3 || latched_mon !== 2'b10 || latched_info !== 8'hD0 || stall_count !== 16'd4) begin
      n_errors++; $display("FAIL tripped_hold: got irq=%0b st=%0d lm=%b li=%h cnt=%0d exp 1/3/10/d0/4", irq, state, latched_mon, latched_info, stall_count);
    end
    cfg_enable = 1'b1; irq_clear = 1'b1; mon_block = 2'b00;
    tick();
    irq_clear = 1'b0;
    n_checks++; if (irq !== 1'b0 || state !== 2'd1 || stall_count !== 16'd0) begin n_errors++; $display("FAIL basic_clear: got irq=%0b st=%0d cnt=%0d exp 0/1/0", irq, state, stall_count); end
    n_checks++; if (latched_mon !== 2'b10 || latched_info !== 8'hD0) begin n_errors++; $display("FAIL latch_after_clear: got %b/%h exp 10/d0", latched_mon, latched_info); end
  endtask

  task automatic test_glitch();
    cfg_threshold = 16'd4; mon_info = 8'h21;
    for (int r = 0; r < 2; r++) begin
      mon_block = 2'b01;
      for (int k = 0; k < 3; k++) begin
        irq_clear = (k == 1);  // clear outside TRIPPED must be a no-op
        tick();
      end
      irq_clear = 1'b0;
      n_checks++; if (stall_count !== 16'd3 || irq !== 1'b0 || state !== 2'd2) begin
        n_errors++; $display("FAIL glitch_run%0d: got cnt=%0d irq=%0b st=%0d exp 3/0/2", r, stall_count, irq, state);
      end
      mon_block = 2'b00;
      tick();
      n_checks++; if (stall_count !== 16'd0 || state !== 2'd1 || irq !== 1'b0) begin
        n_errors++; $display("FAIL glitch_gap%0d: got cnt=%0d st=%0d irq=%0b exp 0/1/0", r, stall_count, state, irq);
      end
    end
  endtask

  task automatic test_threshold_lower();
    cfg_threshold = 16'd10; mon_block = 2'b11; mon_info = 8'h9C;
    tick(); tick(); tick();
    n_checks++; if (stall_count !== 16'd3 || state !== 2'd2) begin n_errors++; $display("FAIL lower_pre: got cnt=%0d st=%0d exp 3/2", stall_count, state); end
    cfg_threshold = 16'd2;
    tick();
    n_checks++; if (irq !== 1'b1 || stall_count !== 16'd4 || trip_count !== 8'd2) begin
      n_errors++; $display("FAIL lower_trip: got irq=%0b cnt=%0d trips=%0d exp 1/4/2", irq, stall_count, trip_count);
    end
    n_checks++; if (latched_mon !== 2'b11 || latched_info !== 8'h9C) begin n_errors++; $display("FAIL lower_latch: got %b/%h exp 11/9c", latched_mon, latched_info); end
    irq_clear = 1'b1; mon_block = 2'b00;
    tick();
    irq_clear = 1'b0;
  endtask

  task automatic test_disable_race();
    cfg_threshold = 16'd3; mon_block = 2'b01;
    tick(); tick();
    n_checks++; if (stall_count !== 16'd2 || state !== 2'd2) begin n_errors++; $display("FAIL drop_pre: got cnt=%0d st=%0d exp 2/2", stall_count, state); end
    cfg_enable = 1'b0;
    tick();
    n_checks++; if (state !== 2'd0 || stall_count !== 16'd0 || irq !== 1'b0 || trip_count !== 8'd2) begin
      n_errors++; $display("FAIL drop_wins: got st=%0d cnt=%0d irq=%0b trips=%0d exp 0/0/0/2", state, stall_count, irq, trip_count);
    end
  endtask

  task automatic test_back_to_back();
    cfg_enable = 1'b1; mon_block = 2'b00;
    tick();
    cfg_threshold = 16'd2; mon_block = 2'b01; mon_info = 8'h5A;
    tick(); tick();
    n_checks++; if (irq !== 1'b1 || trip_count !== 8'd3) begin n_errors++; $display("FAIL race_first: got irq=%0b trips=%0d exp 1/3", irq, trip_count); end
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    n_checks++; if (irq !== 1'b0 || state !== 2'd1 || stall_count !== 16'd0) begin
      n_errors++; $display("FAIL race_clear: got irq=%0b st=%0d cnt=%0d exp 0/1/0", irq, state, stall_count);
    end
    tick();
    n_checks++; if (state !== 2'd2 || stall_count !== 16'd1 || irq !== 1'b0) begin
      n_errors++; $display("FAIL race_recount: got st=%0d cnt=%0d irq=%0b exp 2/1/0", state, stall_count, irq);
    end
    tick();
    n_checks++; if (irq !== 1'b1 || state !== 2'd3 || trip_count !== 8'd4 || latched_info !== 8'h5A) begin
      n_errors++; $display("FAIL race_retrip: got irq=%0b st=%0d trips=%0d li=%h exp 1/3/4/5a", irq, state, trip_count, latched_info);
    end
  endtask

  task automatic test_thr0_disable();
    cfg_threshold = 16'd0; irq_clear = 1'b1; mon_block = 2'b00;
    tick();
    irq_clear = 1'b0;
    n_checks++; if (state !== 2'd1) begin n_errors++; $display("FAIL thr0_armed: got %0d exp 1", state); end
    mon_block = 2'b10; mon_info = 8'h70;
    tick();
    n_checks++; if (irq !== 1'b1 || state !== 2'd3 || stall_count !== 16'd1 || trip_count !== 8'd5 || latched_info !== 8'h70) begin
      n_errors++; $display("FAIL thr0_trip: got irq=%0b st=%0d cnt=%0d trips=%0d li=%h exp 1/3/1/5/70", irq, state, stall_count, trip_count, latched_info);
    end
    cfg_enable = 1'b0; irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    n_checks++; if (state !== 2'd0 || irq !== 1'b0) begin n_errors++; $display("FAIL thr0_clear_idle: got st=%0d irq=%0b exp 0/0", state, irq); end
    tick(); tick(); tick();
    n_checks++; if (state !== 2'd0 || stall_count !== 16'd0 || irq !== 1'b0 || trip_count !== 8'd5) begin
      n_errors++; $display("FAIL idle_ignores_block: got st=%0d cnt=%0d irq=%0b trips=%0d exp 0/0/0/5", state, stall_count, irq, trip_count);
    end
  endtask

  task automatic test_async_reset();
    cfg_enable = 1'b1; cfg_threshold = 16'd1; mon_block = 2'b01; mon_info = 8'hE4;
    tick(); tick();
    n_checks++; if (irq !== 1'b1 || state !== 2'd3) begin n_errors++; $display("FAIL areset_pre: got irq=%0b st=%0d exp 1/3", irq, state); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (irq !== 1'b0 || state !== 2'd0 || stall_count !== 16'd0 || latched_mon !== 2'b00 || latched_info !== 8'h00 || trip_count !== 8'd0) begin
      n_errors++; $display("FAIL areset_immediate: got irq=%0b st=%0d cnt=%0d lm=%b li=%h trips=%0d exp all 0", irq, state, stall_count, latched_mon, latched_info, trip_count);
    end
    cfg_enable = 1'b0; mon_block = 2'b00;
    #1;
    reset_n = 1'b1;
    tick();
    n_checks++; if (state !== 2'd0 || irq !== 1'b0) begin n_errors++; $display("FAIL areset_release: got st=%0d irq=%0b exp 0/0", state, irq); end
  endtask

  task automatic test_saturation();
    cfg_enable = 1'b1; cfg_threshold = 16'd1; mon_block = 2'b01; mon_info = 8'h11;
    tick();
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 99) begin
        n_checks++; if (trip_count !== 8'd100) begin n_errors++; $display("FAIL sat_mid: got %0d exp 100", trip_count); end
      end
      irq_clear = 1'b1;
      tick();
      irq_clear = 1'b0;
    end
    n_checks++; if (trip_count !== 8'd255) begin n_errors++; $display("FAIL sat_final: got %0d exp 255", trip_count); end
    n_checks++; if (state !== 2'd1 || irq !== 1'b0) begin n_errors++; $display("FAIL sat_end_state: got st=%0d irq=%0b exp 1/0", state, irq); end
  endtask

  initial begin
    test_reset();
    test_basic_trip();
    test_glitch();
    test_threshold_lower();
    test_disable_race();
    test_back_to_back();
    test_thr0_disable();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/deadlock_watchdog_ctrl.md
# deadlock_watchdog_ctrl

Watchdog controller that sits above the per-dataflow deadlock monitors of the userdma simulation/debug fabric. It arms on software enable and times consecutive cycles in which any monitor reports a block. When a programmable threshold is reached, it latches which monitors tripped and their AXIS block info, then raises a sticky interrupt until software clears it. A single instance is shared by all monitor instances of one top-level design.

## Interface
- NUM_MON, 2, number of monitor instances observed (1..8)
- INFO_W, 4, width of each monitor's axis_block_info
- THRESH_W, 16, width of threshold and stall counter
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- mon_block  in  NUM_MON  per-monitor block flag, level
- mon_info  in  NUM_MON*INFO_W  per-monitor block info; monitor i occupies [i*INFO_W +: INFO_W]
- cfg_enable  in  1  arm watchdog, level
- cfg_threshold  in  THRESH_W  consecutive blocked cycles to trip; 0 is treated as 1
- irq_clear  in  1  single-cycle pulse; acknowledges a trip
- irq  out  1  sticky trip interrupt
- state  out  2  FSM state encoding
- stall_count  out  THRESH_W  current consecutive blocked-cycle count
- latched_mon  out  NUM_MON  mon_block snapshot at trip
- latched_info  out  NUM_MON*INFO_W  mon_info snapshot at trip
- trip_count  out  8  number of trips since reset, saturating at 255

## Operation
- Define any_block = |mon_block. Define thr_eff = (cfg_threshold == 0) ? 1 : cfg_threshold.
- FSM states: IDLE=0, ARMED=1, COUNTING=2, TRIPPED=3.
- IDLE: stall_count=0. When cfg_enable=1, go to ARMED.
- ARMED:
  - If cfg_enable=0, go to IDLE.
  - Else if any_block, go to COUNTING with stall_count=1. If thr_eff==1, go directly to TRIPPED instead (same capture as below).
- COUNTING:
  - If cfg_enable=0, go to IDLE with count=0.
  - Else if !any_block, go to ARMED with count=0.
  - Else count+1. If count+1 >= thr_eff, go to TRIPPED.
  - The comparison is >=, so lowering the threshold mid-count trips on the next blocked cycle.
- Trip capture, on the transition edge into TRIPPED:
  - latched_mon and latched_info take the values sampled at that edge.
  - irq is set to 1.
  - trip_count increments, saturating at 255.
  - stall_count holds its final value.
- TRIPPED:
  - Ignores mon_block and cfg_enable. irq stays 1.
  - On irq_clear: irq is set to 0 and count to 0. Go to ARMED if cfg_enable=1, else IDLE.
  - latched_* keep their values until the next trip.
- irq_clear outside TRIPPED has no effect.
- Counter never wraps: the trip fires at or before the maximum value 2^THRESH_W-1.

## Timing
- All outputs are registered. No combinational input-to-output path.
- Reset (asynchronous assert, synchronous-to-clock deassert handled externally): state=IDLE, irq=0, stall_count=0, latched_mon=0, latched_info=0, trip_count=0.
- Reset mid-operation, including in TRIPPED, clears everything immediately.
- Enable latency: cfg_enable sampled high at edge k gives state=ARMED after edge k. Blocking is counted from edge k+1 onward.
- Trip latency: with any_block held high at T consecutive sampled edges starting in ARMED, irq=1 after the T-th edge.
- Simultaneous events:
  - irq_clear and any_block in TRIPPED: the clear wins, state=ARMED, count=0. Counting restarts at the next edge.
  - cfg_enable drop and trip condition on the same edge in COUNTING: the disable wins, state=IDLE, no trip.
- A single deasserted any_block cycle in COUNTING fully resets the count. There is no hysteresis.

## Structure
- Package deadlock_wd_pkg holds:
  - the state enum (IDLE/ARMED/COUNTING/TRIPPED, 2-bit);
  - INFO_W default;
  - TRIP_CNT_W=8.
- Single module. The count/compare logic is small enough that no sub-module is warranted.
- Monitors connect by concatenating their block and axis_block_info outputs into mon_block/mon_info.

## Test plan
- Basic trip: NUM_MON=2, threshold=4, enable. Hold mon_block=2'b10, info=8'hD0 for 4 cycles -> irq=1 after the 4th edge, latched_mon=2'b10, latched_info=8'hD0, stall_count=4, trip_count=1.
- Glitch immunity: threshold=4. Pattern of 3 blocked cycles, 1 clear, 3 blocked -> irq never asserts; stall_count returns to 0 on the clear cycle.
- Clear/re-arm race: after a trip, pulse irq_clear while mon_block stays 2'b01 with threshold=2 -> irq=0 for one cycle, state ARMED, re-trips 2 edges later, trip_count=2.
- Threshold 0 and disable: threshold=0 with one blocked cycle -> irq after 1 edge. Then clear with cfg_enable=0 -> state IDLE and blocking is ignored.
- Async reset in TRIPPED: assert reset_n=0 mid-cycle -> irq, latched_*, trip_count and state are 0 immediately, before the next edge.
- Saturation: 300 trip/clear cycles with threshold=1 -> trip_count stops at 255.
